vga_sync_ctrl: RTL and testbench

Timing controller for the MonitorVGA display path. It divides the system clock down to a pixel rate and sequences horizontal and vertical position counters through two phase state machines (active, front porch, sync, back porch). It produces hsync/vsync, a video-enable flag, the current pixel coordinates and frame markers, which the pixel-generation logic downstream consumes.

---
 rtl/vga_sync_ctrl.sv | 117 +++++++++++
 tb/tb_vga_sync_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_ctrl.sv
// vga_sync_ctrl: VGA timing generator. A clock divider produces the pixel
// rate; horizontal and vertical phase machines walk active / front porch /
// sync / back porch and drive the registered sync, blanking and position
// outputs used by the downstream pixel generator.
module vga_sync_ctrl #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int DIV       = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       pixel_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNCP, H_BACK} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNCP, V_BACK} v_state_t;

  logic [DIV_W-1:0] div;
  h_state_t         h_state, h_state_n, h_succ;
  v_state_t         v_state, v_state_n, v_succ;
  logic [9:0]       h_seg, v_seg;
  logic [9:0]       h_len, v_len;
  logic             h_last, v_last;
  logic             tick_now, eol, eof;

  // Tick decode and next-phase selection for both machines
  always_comb begin
    tick_now = enable && (div == DIV_W'(DIV - 1));
    eol      = tick_now && (pixel_x == 10'(H_TOTAL - 1));
    eof      = eol && (pixel_y == 10'(V_TOTAL - 1));

    h_len  = 10'(H_VISIBLE);
    h_succ = H_FRONT;
    case (h_state)
      H_ACT:   begin h_len = 10'(H_VISIBLE); h_succ = H_FRONT; end
      H_FRONT: begin h_len = 10'(H_FP);      h_succ = H_SYNCP; end
      H_SYNCP: begin h_len = 10'(H_SYNC);    h_succ = H_BACK;  end
      H_BACK:  begin h_len = 10'(H_BP);      h_succ = H_ACT;   end
      default: begin h_len = 10'(H_VISIBLE); h_succ = H_ACT;   end
    endcase
    h_last    = (h_seg == h_len - 10'd1);
    h_state_n = h_state;
    if (tick_now && h_last) h_state_n = h_succ;

    v_len  = 10'(V_VISIBLE);
    v_succ = V_FRONT;
    case (v_state)
      V_ACT:   begin v_len = 10'(V_VISIBLE); v_succ = V_FRONT; end
      V_FRONT: begin v_len = 10'(V_FP);      v_succ = V_SYNCP; end
      V_SYNCP: begin v_len = 10'(V_SYNC);    v_succ = V_BACK;  end
      V_BACK:  begin v_len = 10'(V_BP);      v_succ = V_ACT;   end
      default: begin v_len = 10'(V_VISIBLE); v_succ = V_ACT;   end
    endcase
    v_last    = (v_seg == v_len - 10'd1);
    v_state_n = v_state;
    if (eol && v_last) v_state_n = v_succ;
  end

  // Divider, both phase machines, positions and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div         <= '0;
      h_state     <= H_ACT;
      v_state     <= V_ACT;
      h_seg       <= '0;
      v_seg       <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_tick  <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_tick  <= tick_now;
      frame_start <= eof;
      // Blanking is forced while frozen; otherwise it tracks the phase
      // the machines are entering on this edge.
      video_on    <= enable && (h_state_n == H_ACT) && (v_state_n == V_ACT);
      if (enable) begin
        if (tick_now) begin
          div     <= '0;
          h_state <= h_state_n;
          h_seg   <= h_last ? 10'd0 : h_seg + 10'd1;
          pixel_x <= (pixel_x == 10'(H_TOTAL - 1)) ? 10'd0 : pixel_x + 10'd1;
          hsync   <= (h_state_n != H_SYNCP);
          if (eol) begin
            v_state <= v_state_n;
            v_seg   <= v_last ? 10'd0 : v_seg + 10'd1;
            pixel_y <= (pixel_y == 10'(V_TOTAL - 1)) ? 10'd0 : pixel_y + 10'd1;
            vsync   <= (v_state_n != V_SYNCP);
          end
        end else begin
          div <= div + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// tb_vga_sync_ctrl: directed bench for vga_sync_ctrl. Instance A uses the
// default 640x480 timing at DIV=2; instance B uses a tiny 14x7 raster at
// DIV=1 so a full frame and a mid-sync reset fit in a short run.
module tb_vga_sync_ctrl;

  logic       clk = 1'b0;
  logic       rst_a, en_a, rst_b, en_b;
  logic       tick_a, hs_a, vs_a, von_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       tick_b, hs_b, vs_b, von_b, fs_b;
  logic [9:0] x_b, y_b;

  int n_assert = 0;
  int n_fail   = 0;
  int e        = 0;

  always #5 clk = ~clk;

  vga_sync_ctrl dut_a (
    .clk(clk), .reset(rst_a), .enable(en_a),
    .pixel_tick(tick_a), .pixel_x(x_a), .pixel_y(y_a),
    .hsync(hs_a), .vsync(vs_a), .video_on(von_a), .frame_start(fs_a)
  );

  vga_sync_ctrl #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .DIV(1)
  ) dut_b (
    .clk(clk), .reset(rst_b), .enable(en_b),
    .pixel_tick(tick_b), .pixel_x(x_b), .pixel_y(y_b),
    .hsync(hs_b), .vsync(vs_b), .video_on(von_b), .frame_start(fs_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    e += n;
  endtask

  task automatic step_to(input int target);
    step(target - e);
  endtask

  initial begin
    int ticks;
    int moved;
    int p, ex, ey;

    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("a_rst_tick", tick_a, 0);
    chk("a_rst_x", x_a, 0);
    chk("a_rst_y", y_a, 0);
    chk("a_rst_hs", hs_a, 1);
    chk("a_rst_vs", vs_a, 1);
    chk("a_rst_von", von_a, 0);
    chk("a_rst_fs", fs_a, 0);

    rst_a = 1'b0; e = 0;
    step(1);
    chk("a_e1_von", von_a, 1);
    chk("a_e1_tick", tick_a, 0);
    chk("a_e1_x", x_a, 0);
    step(1);
    chk("a_e2_tick", tick_a, 1);
    chk("a_e2_x", x_a, 1);
    step(1);
    chk("a_e3_tick", tick_a, 0);
    chk("a_e3_x", x_a, 1);
    step(1);
    chk("a_e4_tick", tick_a, 1);
    chk("a_e4_x", x_a, 2);

    step_to(1278);
    chk("a_x639", x_a, 639);
    chk("a_x639_von", von_a, 1);
    step_to(1280);
    chk("a_x640", x_a, 640);
    chk("a_x640_von", von_a, 0);
    step_to(1310);
    chk("a_x655", x_a, 655);
    chk("a_x655_hs", hs_a, 1);
    step_to(1312);
    chk("a_x656", x_a, 656);
    chk("a_x656_hs", hs_a, 0);
    chk("a_x656_tick", tick_a, 1);
    step_to(1502);
    chk("a_x751", x_a, 751);
    chk("a_x751_hs", hs_a, 0);
    step_to(1504);
    chk("a_x752", x_a, 752);
    chk("a_x752_hs", hs_a, 1);
    step_to(1598);
    chk("a_x799", x_a, 799);
    chk("a_x799_y", y_a, 0);
    step_to(1600);
    chk("a_wrap_x", x_a, 0);
    chk("a_wrap_y", y_a, 1);
    chk("a_wrap_von", von_a, 1);
    chk("a_wrap_fs", fs_a, 0);
    chk("a_wrap_vs", vs_a, 1);

    step_to(2200);
    chk("a_x300", x_a, 300);
    chk("a_x300_tick", tick_a, 1);
    en_a = 1'b0;
    step(1);
    chk("a_dis_tick", tick_a, 0);
    chk("a_dis_von", von_a, 0);
    chk("a_dis_x", x_a, 300);
    ticks = 0; moved = 0;
    for (int i = 0; i < 49; i++) begin
      step(1);
      if (tick_a) ticks++;
      if (x_a != 10'd300) moved++;
    end
    chk("a_dis_ticks", ticks, 0);
    chk("a_dis_moved", moved, 0);
    en_a = 1'b1;
    step(1);
    chk("a_re1_x", x_a, 300);
    chk("a_re1_tick", tick_a, 0);
    chk("a_re1_von", von_a, 1);
    step(1);
    chk("a_re2_x", x_a, 301);
    chk("a_re2_tick", tick_a, 1);
    step(1);
    chk("a_pre_tick", tick_a, 0);
    en_a = 1'b0;
    step(1);
    chk("a_wrapdis_tick", tick_a, 0);
    chk("a_wrapdis_x", x_a, 301);
    en_a = 1'b1;
    step(1);
    chk("a_resume_tick", tick_a, 1);
    chk("a_resume_x", x_a, 302);
    rst_a = 1'b1;

    rst_b = 1'b0; e = 0;
    for (int k = 1; k <= 196; k++) begin
      step(1);
      p  = e % 98;
      ex = p % 14;
      ey = p / 14;
      chk($sformatf("b_tick_e%0d", e), tick_b, 1);
      chk($sformatf("b_x_e%0d", e), x_b, ex);
      chk($sformatf("b_y_e%0d", e), y_b, ey);
      chk($sformatf("b_hs_e%0d", e), hs_b, (ex >= 10 && ex <= 11) ? 0 : 1);
      chk($sformatf("b_vs_e%0d", e), vs_b, (ey == 5) ? 0 : 1);
      chk($sformatf("b_von_e%0d", e), von_b, (ex < 8 && ey < 4) ? 1 : 0);
      chk($sformatf("b_fs_e%0d", e), fs_b, (p == 0) ? 1 : 0);
    end

    step(81);
    chk("b_pre_rst_x", x_b, 11);
    chk("b_pre_rst_y", y_b, 5);
    chk("b_pre_rst_hs", hs_b, 0);
    chk("b_pre_rst_vs", vs_b, 0);
    #2;
    rst_b = 1'b1;
    #1;
    chk("b_rst_tick", tick_b, 0);
    chk("b_rst_x", x_b, 0);
    chk("b_rst_y", y_b, 0);
    chk("b_rst_hs", hs_b, 1);
    chk("b_rst_vs", vs_b, 1);
    chk("b_rst_von", von_b, 0);
    chk("b_rst_fs", fs_b, 0);
    step(2);
    chk("b_rst_hold_fs", fs_b, 0);
    chk("b_rst_hold_x", x_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
